// File: rtl/modp_pkg.sv
// Shared constants and types for the modulo-p reduction scheduler.
// p = 2^255 - 19: every bit set above bit 4, low five bits 01101.
package modp_pkg;

  localparam logic [254:0] P_MODULUS = {{250{1'b1}}, 5'b01101};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} modp_state_t;

  function automatic int gnt_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/modp_sched_if.sv
// Requester handshakes plus the reduction-engine port, bundled for modp_sched.
interface modp_sched_if #(
  parameter int NREQ = 4,
  parameter int N    = 256
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [255:0]      rsp_data;
  logic              eng_start;
  logic [N-1:0]      eng_n;
  logic              eng_done;
  logic [255:0]      eng_rem;

  modport slave (
    input  req_valid, req_data, rsp_ready, eng_done, eng_rem,
    output req_ready, rsp_valid, rsp_data, eng_start, eng_n
  );

  modport master (
    output req_valid, req_data, rsp_ready, eng_done, eng_rem,
    input  req_ready, rsp_valid, rsp_data, eng_start, eng_n
  );
endinterface

// File: rtl/modp_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after
// i_ptr wins, wrapping past NREQ-1 back to 0.
module rr_arbiter
  import modp_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int GW   = gnt_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [GW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [GW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin : pick
    logic [GW-1:0] w_j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = GW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/modp_sched.sv
// Shares one mod-p reduction engine among NREQ requesters; operands already
// below p skip the engine and are returned directly.
module modp_sched
  import modp_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int N    = 256,
  localparam int GW   = gnt_w(NREQ)
) (
  input  logic         clk,
  input  logic         rst,
  modp_sched_if.slave  bus,
  output logic         o_busy,
  output logic [15:0]  o_eng_uses
);

  localparam logic [N-1:0] P_EXT = {{(N-255){1'b0}}, P_MODULUS};

  modp_state_t     r_state, w_next;
  logic [GW-1:0]   r_rr, r_gnt, w_idx;
  logic [NREQ-1:0] w_gnt_oh;
  logic            w_any;
  logic [N-1:0]    r_op, w_op_in;
  logic [255:0]    r_rsp;
  logic [15:0]     r_eng_uses;
  logic            w_accept, w_bypass, w_rsp_hs;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_rr),
    .o_gnt (w_gnt_oh),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_op_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == GW'(i)) w_op_in = bus.req_data[i*N +: N];
    end
  end

  assign w_bypass = (w_op_in < P_EXT);
  assign w_accept = (r_state == IDLE) && w_any;
  assign w_rsp_hs = (r_state == RESP) && bus.rsp_ready[r_gnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.eng_start = 1'b0;
    bus.eng_n     = '0;
    o_busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        bus.req_ready = w_gnt_oh;
        if (w_any) w_next = w_bypass ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.eng_start = 1'b1;
        bus.eng_n     = r_op;
        w_next        = WAIT;
      end
      WAIT: begin
        // operand stays on eng_n until the engine reports done
        bus.eng_n = r_op;
        if (bus.eng_done) w_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
        bus.rsp_data  = r_rsp;
        if (bus.rsp_ready[r_gnt]) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr       <= '0;
      r_gnt      <= '0;
      r_op       <= '0;
      r_rsp      <= '0;
      r_eng_uses <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= w_op_in;
        r_gnt <= w_idx;
        if (w_bypass) r_rsp <= w_op_in[255:0];
      end
      if (r_state == ISSUE && r_eng_uses != 16'hFFFF) r_eng_uses <= r_eng_uses + 16'd1;
      if (r_state == WAIT && bus.eng_done) r_rsp <= bus.eng_rem;
      if (w_rsp_hs) r_rr <= (r_gnt == GW'(NREQ-1)) ? '0 : r_gnt + GW'(1);
    end
  end

  assign o_eng_uses = r_eng_uses;

endmodule

// File: tb/tb_modp_sched.sv
// Directed bench for modp_sched with a 6-cycle behavioural reduction engine.
module tb_modp_sched;
  import modp_pkg::*;

  localparam logic [255:0] P    = {1'b0, {250{1'b1}}, 5'b01101};
  localparam logic [255:0] ONES = {256{1'b1}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] eng_uses;

  int total = 0;
  int bad   = 0;
  int n_start = 0;

  modp_sched_if #(.NREQ(4), .N(256)) bus ();

  modp_sched #(.NREQ(4), .N(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .o_busy     (busy),
    .o_eng_uses (eng_uses)
  );

  always #5 clk = ~clk;

  // engine model: result 6 cycles after launch, cleared by the shared reset
  logic         m_done, f_done;
  logic [255:0] m_rem, f_rem, m_hold;
  int           m_cnt;

  function automatic logic [255:0] reduce(input logic [255:0] op);
    logic [256:0] x;
    x = {1'b0, op};
    if (x >= {P, 1'b0})      x = x - {P, 1'b0};
    else if (x >= {1'b0, P}) x = x - {1'b0, P};
    return x[255:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_rem  <= '0;
      m_hold <= '0;
    end else begin
      m_done <= 1'b0;
      if (bus.eng_start) begin
        m_cnt  <= 6;
        m_hold <= reduce(bus.eng_n);
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_rem  <= m_hold;
        end
      end
    end
  end

  assign bus.eng_done = m_done | f_done;
  assign bus.eng_rem  = f_done ? f_rem : m_rem;

  always @(posedge clk) if (bus.eng_start) n_start++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    logic done_before;
    int   n;
    n = 0;
    done_before = 1'b0;
    while (bus.rsp_valid == '0 && n < 40) begin
      done_before = bus.eng_done;
      tick();
      n++;
    end
    check({tag, "_rsp_seen"}, bus.rsp_valid != '0, 1'b1);
    check({tag, "_done_lat"}, done_before, 1'b1);
  endtask

  task automatic do_req(input int idx, input logic [255:0] data,
                        input logic [255:0] exp, input bit eng, input string tag);
    bus.req_valid = 4'b0001 << idx;
    bus.req_data[idx*256 +: 256] = data;
    bus.rsp_ready = '0;
    #1;
    check({tag, "_ready"}, bus.req_ready, 4'b0001 << idx);
    tick();
    bus.req_valid = '0;
    #1;
    if (eng) begin
      check({tag, "_start"}, bus.eng_start, 1'b1);
      check({tag, "_eng_n"}, bus.eng_n, data);
      wait_rsp(tag);
    end else begin
      check({tag, "_nostart"}, bus.eng_start, 1'b0);
    end
    check({tag, "_valid"}, bus.rsp_valid, 4'b0001 << idx);
    check({tag, "_data"}, bus.rsp_data, exp);
    bus.rsp_ready = 4'b0001 << idx;
    tick();
    bus.rsp_ready = '0;
    #1;
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_rsp_clr"}, bus.rsp_valid, 4'b0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int starts0, g;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = '0;
    f_done = 1'b0;
    f_rem  = '0;

    // reset values
    #12;
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_rsp_valid", bus.rsp_valid, 4'b0000);
    check("rst_rsp_data", bus.rsp_data, 256'd0);
    check("rst_eng_start", bus.eng_start, 1'b0);
    check("rst_eng_n", bus.eng_n, 256'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_eng_uses", eng_uses, 16'd0);
    rst = 1'b0;
    tick();

    // bypass, then engine path
    starts0 = n_start;
    do_req(1, 256'd5, 256'd5, 1'b0, "byp5");
    check("byp5_no_launch", n_start - starts0, 256'd0);
    do_req(0, P + 256'd7, 256'd7, 1'b1, "engp7");
    check("engp7_one_launch", n_start - starts0, 256'd1);
    check("engp7_uses", eng_uses, 16'd1);

    // boundaries; last one from requester 3 leaves rr at 0
    do_req(1, P, 256'd0, 1'b1, "eq_p");
    do_req(2, P - 256'd1, P - 256'd1, 1'b0, "p_m1");
    do_req(3, ONES, 256'd37, 1'b1, "all1");
    check("bound_uses", eng_uses, 16'd3);

    // fairness with every requester pending
    for (int i = 0; i < 4; i++) bus.req_data[i*256 +: 256] = P + 256'(i);
    bus.req_valid = 4'hF;
    bus.rsp_ready = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      check("fair_ready", bus.req_ready, 4'b0001 << g);
      tick();
      check("fair_start", bus.eng_start, 1'b1);
      check("fair_no_ready", bus.req_ready, 4'b0000);
      wait_rsp("fair");
      check("fair_valid", bus.rsp_valid, 4'b0001 << g);
      check("fair_data", bus.rsp_data, 256'(g));
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    check("fair_uses", eng_uses, 16'd8);

    // backpressure on requester 2
    bus.req_valid = 4'b0100;
    bus.req_data[2*256 +: 256] = 256'd42;
    #1;
    check("bp_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'b1011;
    bus.rsp_ready = 4'b1011;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", bus.rsp_valid, 4'b0100);
      check("bp_data", bus.rsp_data, 256'd42);
      check("bp_no_ready", bus.req_ready, 4'b0000);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 4'b0100;
    tick();
    bus.rsp_ready = '0;
    check("bp_idle", busy, 1'b0);
    check("bp_rsp_clr", bus.rsp_valid, 4'b0000);

    // reset while waiting on the engine
    bus.req_valid = 4'b0001;
    bus.req_data[0 +: 256] = P + 256'd9;
    tick();
    bus.req_valid = '0;
    tick();
    check("wrst_in_wait", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("wrst_req_ready", bus.req_ready, 4'b0000);
    check("wrst_rsp_valid", bus.rsp_valid, 4'b0000);
    check("wrst_rsp_data", bus.rsp_data, 256'd0);
    check("wrst_eng_start", bus.eng_start, 1'b0);
    check("wrst_eng_n", bus.eng_n, 256'd0);
    check("wrst_busy", busy, 1'b0);
    check("wrst_eng_uses", eng_uses, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    f_done = 1'b1;
    f_rem  = 256'd123;
    tick();
    f_done = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("stray_rsp_valid", bus.rsp_valid, 4'b0000);
    check("stray_busy", busy, 1'b0);
    do_req(1, 256'd5, 256'd5, 1'b0, "post_byp");
    do_req(2, P + 256'd11, 256'd11, 1'b1, "post_eng");
    check("post_uses", eng_uses, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
